// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: sequences one UART transmit frame per accepted byte
// (start bit, data LSB-first, optional parity bit, stop bit(s)) and owns the
// baud-interval counter. All outputs are registered.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits; p_type (0 = even, 1 = odd) is latched with the byte. Without the macro
// the parity state and parity register do not exist and p_type is ignored.
module uart_tx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 p_type,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [DATA_BITS-1:0]   shreg, shreg_nx;
    logic                   tx_nx, tx_ready_nx, busy_nx, done_nx;
    logic                   bit_end;

`ifdef UART_TX_PARITY_EN
    logic                   par_bit, par_bit_nx;
`else
    logic                   unused_p_type;
    assign unused_p_type = p_type;
`endif

    // A serial bit ends on the last cycle of its baud interval.
    assign bit_end = (cnt == CNT_LAST);

    // State register plus registered outputs; reset forces the line idle-high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            shreg    <= shreg_nx;
            tx       <= tx_nx;
            tx_ready <= tx_ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
`ifdef UART_TX_PARITY_EN
            par_bit  <= par_bit_nx;
`endif
        end
    end

    // Next-state and next-output logic; tx is computed one cycle ahead so it
    // only moves on bit boundaries.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        shreg_nx    = shreg;
        tx_nx       = tx;
        tx_ready_nx = tx_ready;
        busy_nx     = busy;
        done_nx     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_bit_nx  = par_bit;
`endif

        if (state != S_IDLE) begin
            cnt_nx = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nx    = S_START;
                    cnt_nx      = '0;
                    idx_nx      = '0;
                    shreg_nx    = tx_data;
                    tx_nx       = 1'b0;
                    tx_ready_nx = 1'b0;
                    busy_nx     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_bit_nx  = (^tx_data) ^ p_type;
`endif
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_nx = S_DATA;
                    idx_nx   = '0;
                    tx_nx    = shreg[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    shreg_nx = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
`ifdef UART_TX_PARITY_EN
                        state_nx = S_PARITY;
                        tx_nx    = par_bit;
`else
                        state_nx = S_STOP;
                        tx_nx    = 1'b1;
`endif
                    end else begin
                        idx_nx = idx + 1'b1;
                        tx_nx  = shreg[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nx = S_STOP;
                    idx_nx   = '0;
                    tx_nx    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                // done is registered, so raise it one cycle early to land on
                // the final cycle of the last stop bit.
                if (idx == STOP_LAST && cnt == CNT_PRE) begin
                    done_nx = 1'b1;
                end
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        state_nx    = S_IDLE;
                        idx_nx      = '0;
                        tx_ready_nx = 1'b1;
                        busy_nx     = 1'b0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end

            default: begin
                state_nx    = S_IDLE;
                cnt_nx      = '0;
                idx_nx      = '0;
                tx_nx       = 1'b1;
                tx_ready_nx = 1'b1;
                busy_nx     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl (CLKS_PER_BIT=4, DATA_BITS=8,
// STOP_BITS=1). Stimulus pushes hand-computed frames; a monitor pops them
// when a start bit appears on tx and checks every cycle of the frame.
module tb_uart_tx_frame_ctrl;

    localparam int CPB  = 4;
    localparam int HALF = 5;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       p_type = 1'b0;
    logic       tx_ready, tx, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        time         acc_time;
        int          gap;
        bit          abort;
        int          tag;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_frame_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .p_type  (p_type),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #HALF clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // fp = {stop, parity, data[7:0], start}, fn = {stop, data[7:0], start};
    // bit 0 is the first bit on the line.
    task automatic send(input logic [7:0] d, input logic pt, input logic [10:0] fp,
                        input logic [9:0] fn, input int gap, input bit ab,
                        input int tag, input bit hold);
        exp_t e;
        int n;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        p_type   = pt;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            check($sformatf("tag%0d_accept_timeout", tag), tx_ready, 1);
            tx_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.acc_time = $time;
            #1;
            tx_valid = hold;
            tx_data  = ~d;
            p_type   = ~pt;
            e.bits   = (NB == 11) ? {1'b0, fp} : {2'b00, fn};
            e.nbits  = NB;
            e.gap    = gap;
            e.abort  = ab;
            e.tag    = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        bit idle;
        n = 0;
        idle = 0;
        while (!idle && n < 1000) begin
            @(negedge clk);
            n++;
            idle = (exp_q.size() == 0) && (busy === 1'b0);
        end
        if (!idle) check("idle_timeout", busy, 0);
    endtask

    // Monitor: detect start bits, pop the expected frame and check it cycle by cycle.
    initial begin : monitor
        exp_t e;
        int   idle_cnt;
        bit   have_prev, aborted, bit_ok, ctl_ok, done_ok, last;
        logic bad_val;
        idle_cnt  = 0;
        have_prev = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                idle_cnt  = 0;
                have_prev = 0;
            end else begin
                if (done !== 1'b0) check("done_outside_frame", done, 0);
                if (tx !== 1'b0) begin
                    idle_cnt++;
                end else if (exp_q.size() == 0) begin
                    check("frame_expected", exp_q.size(), 1);
                    while (tx === 1'b0 && reset === 1'b0) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tag%0d_start_latency", e.tag), 32'($time - e.acc_time), HALF);
                    if (have_prev && e.gap >= 0)
                        check($sformatf("tag%0d_interframe_gap", e.tag), idle_cnt, e.gap);
                    aborted = 0;
                    ctl_ok  = 1;
                    done_ok = 1;
                    for (int b = 0; b < e.nbits && !aborted; b++) begin
                        bit_ok  = 1;
                        bad_val = e.bits[b];
                        for (int c = 0; c < CPB; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (reset !== 1'b0) begin
                                aborted = 1;
                                break;
                            end
                            if (tx !== e.bits[b]) begin
                                bit_ok  = 0;
                                bad_val = tx;
                            end
                            if (tx_ready !== 1'b0 || busy !== 1'b1) ctl_ok = 0;
                            last = (b == e.nbits - 1) && (c == CPB - 1);
                            if (done !== last) done_ok = 0;
                        end
                        if (!aborted)
                            check($sformatf("tag%0d_bit%0d", e.tag, b), bad_val, e.bits[b]);
                    end
                    check($sformatf("tag%0d_aborted", e.tag), aborted, e.abort);
                    if (!aborted) begin
                        check($sformatf("tag%0d_ready_low_busy_high", e.tag), ctl_ok, 1);
                        check($sformatf("tag%0d_done_last_cycle_only", e.tag), done_ok, 1);
                    end
                    have_prev = !aborted;
                    idle_cnt  = 0;
                end
            end
        end
    end

    // Stimulus: directed frames with hand-computed line patterns.
    initial begin : stim
        int lows;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hold_tx", tx, 1);
        check("rst_hold_ready", tx_ready, 1);
        check("rst_hold_busy", busy, 0);
        check("rst_hold_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rel_tx", tx, 1);
        check("rst_rel_ready", tx_ready, 1);
        check("rst_rel_busy", busy, 0);
        check("rst_rel_done", done, 0);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("idle_line_quiet", lows, 0);

        // 0x55 even: parity 0
        send(8'h55, 1'b0, 11'b1_0_01010101_0, 10'b1_01010101_0, -1, 0, 2, 0);
        wait_idle();
        // 0x07 odd: parity 0; 0x07 even: parity 1
        send(8'h07, 1'b1, 11'b1_0_00000111_0, 10'b1_00000111_0, -1, 0, 3, 0);
        wait_idle();
        send(8'h07, 1'b0, 11'b1_1_00000111_0, 10'b1_00000111_0, -1, 0, 4, 0);
        wait_idle();

        // back-to-back with tx_valid held: exactly one idle-high cycle between frames
        send(8'hA5, 1'b0, 11'b1_0_10100101_0, 10'b1_10100101_0, -1, 0, 5, 1);
        send(8'h3C, 1'b1, 11'b1_1_00111100_0, 10'b1_00111100_0, 1, 0, 6, 0);
        wait_idle();

        // reset during data bit 3 of 0xFF aborts the frame
        send(8'hFF, 1'b0, 11'b1_0_11111111_0, 10'b1_11111111_0, -1, 1, 7, 0);
        repeat (18) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_tx_high", tx, 1);
        check("abort_busy_low", busy, 0);
        check("abort_ready_high", tx_ready, 1);
        check("abort_no_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send(8'h01, 1'b0, 11'b1_1_00000001_0, 10'b1_00000001_0, -1, 0, 8, 0);
        wait_idle();

        // 0x80 even
        send(8'h80, 1'b0, 11'b1_1_10000000_0, 10'b1_10000000_0, -1, 0, 9, 0);
        wait_idle();

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
